apb_spi_cmd_master: RTL and testbench

//  APB3 requester that sits directly upstream of the SPI subsystem's APB slave port.

---
 rtl/apb_spi_cmd_master_pkg.sv | 23 ++
 rtl/apb_spi_cmd_master.sv | 174 +++++++++++++++++
 tb/tb_apb_spi_cmd_master.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_spi_cmd_master_pkg.sv
// Shared FSM encoding and SPI register map for the APB command master and its users.
package apb_spi_cmd_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // SPI block register offsets
    localparam logic [31:0] SPI_CR1     = 32'h0000_0000;
    localparam logic [31:0] SPI_CR2     = 32'h0000_0004;
    localparam logic [31:0] SPI_SR      = 32'h0000_0008;
    localparam logic [31:0] SPI_DR      = 32'h0000_000C;
    localparam logic [31:0] SPI_I2SCFGR = 32'h0000_001C;
    localparam logic [31:0] SPI_I2SPR   = 32'h0000_0020;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/apb_spi_cmd_master.sv
// APB3 requester: one valid/ready command in, one APB SETUP/ACCESS transfer, one response out.
// Latency: accept at edge N, rsp_valid visible after edge N+2+waits (4 cycles min per command).
// Backpressure: single outstanding command; cmd_ready stays low until the response is taken.
module apb_spi_cmd_master
    import apb_spi_cmd_master_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic [7:0]        err_count,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic                busy_q, busy_d;
    logic [7:0]          err_count_q, err_count_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Outputs are registered, so each _d reflects the state being entered.
    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = 1'b0;
        psel_d        = 1'b0;
        penable_d     = 1'b0;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        busy_d        = 1'b1;
        err_count_d   = err_count_q;
        cnt_d         = cnt_q;

        case (state_q)
            ST_IDLE: begin
                busy_d      = 1'b0;
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_wdata;
                    psel_d      = 1'b1;
                    busy_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                if (PREADY) begin
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                rsp_valid_d = 1'b1;
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    cmd_ready_d = 1'b1;
                    if (rsp_err_q) err_count_d = sat_inc8(err_count_q);
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            err_count_q   <= 8'd0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
            err_count_q   <= err_count_d;
            cnt_q         <= cnt_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = busy_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_apb_spi_cmd_master.sv
// Randomized scoreboard bench for apb_spi_cmd_master with an APB slave model and response monitor.
module tb_apb_spi_cmd_master;
    import apb_spi_cmd_master_pkg::*;

    localparam int TMO = 16;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout, busy;
    logic [7:0]  err_count;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    apb_spi_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy), .err_count(err_count),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        bit          w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          waits;
        bit          slverr;
    } cfg_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        bit          tmo;
        int          rise;
    } exp_t;

    cfg_t slv_q[$];
    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   m_errcnt = 0;
    int   last_rsp_hs = -100;
    int   bp_mode = 2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int n_access(input int waits);
        return (TMO != 0 && waits >= TMO) ? TMO : waits + 1;
    endfunction

    function automatic exp_t model(input cfg_t c, input int hs_edge);
        exp_t e;
        e.tmo   = (TMO != 0) && (c.waits >= TMO);
        e.err   = e.tmo || c.slverr;
        e.rdata = (e.tmo || c.w) ? 32'd0 : c.prdata;
        e.rise  = hs_edge + 1 + n_access(c.waits);
        return e;
    endfunction

    function automatic cfg_t rand_cfg(input int max_waits);
        cfg_t c;
        logic [31:0] regs [6];
        regs[0] = SPI_CR1; regs[1] = SPI_CR2; regs[2] = SPI_SR;
        regs[3] = SPI_DR;  regs[4] = SPI_I2SCFGR; regs[5] = SPI_I2SPR;
        c.w      = 1'($urandom_range(0, 1));
        c.addr   = regs[$urandom_range(0, 5)];
        c.wdata  = $urandom;
        c.prdata = $urandom;
        c.waits  = $urandom_range(0, max_waits);
        c.slverr = ($urandom_range(0, 4) == 0);
        return c;
    endfunction

    function automatic cfg_t mk_cfg(input bit w, input logic [31:0] a, input logic [31:0] wd,
                                    input logic [31:0] rd, input int waits, input bit se);
        cfg_t c;
        c.w = w; c.addr = a; c.wdata = wd; c.prdata = rd; c.waits = waits; c.slverr = se;
        return c;
    endfunction

    task automatic send(input cfg_t c, input bit chk_b2b);
        int hs_edge;
        bit got;
        @(posedge PCLK); #2;
        cmd_valid = 1'b1; cmd_write = c.w; cmd_addr = c.addr; cmd_wdata = c.wdata;
        got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge PCLK);
            if (cmd_ready) begin got = 1'b1; break; end
        end
        if (!got) begin
            check("cmd_accept_timeout", 64'd0, 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        hs_edge = cyc + 1;
        if (chk_b2b) check("b2b_accept_edge", hs_edge, last_rsp_hs + 1);
        @(posedge PCLK);
        slv_q.push_back(c);
        exp_q.push_back(model(c, hs_edge));
        #2;
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    endtask

    task automatic drain();
        for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(negedge PCLK);
        check("drain_empty", exp_q.size(), 0);
    endtask

    // APB slave model: waits a per-command number of cycles, junk on PRDATA/PSLVERR otherwise
    initial begin
        cfg_t cur;
        int   acc;
        bit   active;
        active = 1'b0; acc = 0;
        cur = mk_cfg(0, 0, 0, 0, 0, 0);
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        forever begin
            @(posedge PCLK); #1;
            if (PRESET) begin active = 1'b0; PREADY = 1'b0; continue; end
            if (active && !(PSEL && PENABLE)) begin
                check("access_cycles", acc, n_access(cur.waits));
                active = 1'b0;
            end
            if (PSEL && !PENABLE) begin
                check("psel_during_rsp", rsp_valid, 0);
                if (slv_q.size() == 0) check("unexpected_setup", 64'd1, 64'd0);
                else cur = slv_q.pop_front();
                active = 1'b1; acc = 0;
                check("setup_pwrite", PWRITE, cur.w);
                check("setup_paddr", PADDR, cur.addr);
                check("setup_pwdata", PWDATA, cur.wdata);
            end
            if (PSEL && PENABLE && active) begin
                check("access_paddr", PADDR, cur.addr);
                check("access_pwdata", PWDATA, cur.wdata);
                acc++;
                if (acc == cur.waits + 1) begin
                    PREADY = 1'b1; PRDATA = cur.prdata; PSLVERR = cur.slverr;
                end else begin
                    PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
                end
            end else begin
                PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
            end
        end
    end

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge PCLK); #2;
            case (bp_mode)
                0:       rsp_ready = ($urandom_range(0, 3) != 0);
                1:       rsp_ready = 1'b0;
                default: rsp_ready = 1'b1;
            endcase
        end
    end

    // Response monitor
    initial begin
        bit          prev_v, prev_r, prev_e, prev_t;
        logic [31:0] prev_d;
        exp_t        e;
        prev_v = 0; prev_r = 0; prev_e = 0; prev_t = 0; prev_d = '0;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin prev_v = 0; continue; end
            if (rsp_valid && !prev_v) begin
                if (exp_q.size() == 0) check("spurious_rsp", 64'd1, 64'd0);
                else check("rsp_latency_edge", cyc, exp_q[0].rise);
            end
            if (prev_v && !prev_r) begin
                check("rsp_hold_valid", rsp_valid, 1);
                check("rsp_hold_rdata", rsp_rdata, prev_d);
                check("rsp_hold_err", rsp_err, prev_e);
                check("rsp_hold_tmo", rsp_timeout, prev_t);
            end
            if (rsp_valid) check("cmd_ready_in_rsp", cmd_ready, 0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_without_cmd", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_timeout", rsp_timeout, e.tmo);
                end
                check("err_count", err_count, m_errcnt);
                if (rsp_err === 1'b1 && m_errcnt < 255) m_errcnt++;
                last_rsp_hs = cyc + 1;
            end
            prev_v = rsp_valid; prev_r = rsp_ready;
            prev_d = rsp_rdata; prev_e = rsp_err; prev_t = rsp_timeout;
        end
    end

    initial begin
        bit seen;
        PRESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_err_count", err_count, 0);
        check("rst_paddr", PADDR, 0);
        repeat (2) @(posedge PCLK);
        #3 PRESET = 1'b0;
        #1 check("cmd_ready_before_edge", cmd_ready, 0);
        @(posedge PCLK); #1;
        check("cmd_ready_after_rst", cmd_ready, 1);

        // zero-wait write, 3-wait read, boundary waits around TIMEOUT
        bp_mode = 2;
        send(mk_cfg(1, SPI_CR1, 32'h0000_0344, 32'hDEAD_BEEF, 0, 0), 0);
        send(mk_cfg(0, SPI_DR,  32'h1234_5678, 32'h0000_00A5, 3, 0), 0);
        send(mk_cfg(0, SPI_SR,  32'h0,         32'h0000_0055, TMO - 1, 0), 0);
        send(mk_cfg(0, SPI_SR,  32'h0,         32'h0000_0066, 100, 0), 0);
        send(mk_cfg(1, SPI_CR2, 32'h0000_0001, 32'h0,         0, 1), 0);
        drain();

        // backpressure: rsp held 5 cycles, next command queued behind it
        bp_mode = 1;
        send(mk_cfg(0, SPI_I2SPR, 32'h0, 32'h0000_0002, 1, 0), 0);
        fork
            send(mk_cfg(1, SPI_I2SCFGR, 32'h0000_0B00, 32'h0, 0, 0), 1);
            begin
                seen = 1'b0;
                for (int k = 0; k < 50; k++) begin
                    @(negedge PCLK);
                    if (rsp_valid) begin seen = 1'b1; break; end
                end
                check("bp_rsp_seen", seen, 1);
                for (int k = 0; k < 5; k++) begin
                    @(negedge PCLK);
                    check("bp_cmd_ready", cmd_ready, 0);
                    check("bp_no_psel", PSEL, 0);
                end
                bp_mode = 2;
            end
        join
        drain();

        // randomized mix with random response backpressure
        bp_mode = 0;
        for (int i = 0; i < 60; i++) send(rand_cfg(20), 0);
        drain();

        // error saturation
        bp_mode = 2;
        for (int i = 0; i < 300; i++)
            send(mk_cfg(1'($urandom), SPI_DR, $urandom, $urandom, 0, 1), 0);
        drain();
        @(negedge PCLK);
        check("err_count_saturated", err_count, 255);

        // reset during ACCESS wait states
        send(mk_cfg(0, SPI_DR, 32'h0, 32'h0000_0077, 10, 0), 0);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge PCLK); #3;
            if (PSEL && PENABLE) begin seen = 1'b1; break; end
        end
        check("reach_access", seen, 1);
        @(posedge PCLK); #3;
        PRESET = 1'b1;
        #1;
        check("arst_psel", PSEL, 0);
        check("arst_penable", PENABLE, 0);
        check("arst_busy", busy, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        exp_q.delete();
        slv_q.delete();
        m_errcnt = 0;
        @(posedge PCLK); #3;
        PRESET = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_rsp_valid", rsp_valid, 0);
        check("post_rst_err_count", err_count, 0);

        bp_mode = 0;
        for (int i = 0; i < 20; i++) send(rand_cfg(18), 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
